uart_tx_driver: RTL and testbench

//  Serial transmitter for the MIDI/UART link: accepts bytes over a valid/ready handshake,

---
 rtl/uart_tx_driver.sv | 154 +++++++++++++++
 tb/tb_uart_tx_driver.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_driver.sv
// uart_tx_driver: small byte FIFO feeding a serial transmitter (8N1, LSB first, line idle high).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx_driver #(
  parameter int CLOCKS_PER_BIT = 1600,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock_50_000_000,
  input  logic       reset,
  input  logic [7:0] data_out,
  input  logic       data_out_valid,
  output logic       data_out_ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_driver: CLOCKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_driver: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Handshake: a byte moves on any rising edge where data_out_valid && data_out_ready.
  // Ready depends only on FIFO fullness and reset, never on valid, so valid may change freely.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_out_ready = !fifo_full && !reset;
  assign push           = data_out_valid && data_out_ready;
  assign fifo_head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: clearing the pointers discards every entry.
  always_ff @(posedge clock_50_000_000) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_out;
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_next;
  logic [7:0]       tx_byte;
  logic             line_next;
  logic             bit_done;

  assign bit_done = (baud_cnt == CNT_LAST);
  assign busy     = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      uart_tx  <= line_next;
      if (pop) tx_byte <= fifo_head;
    end
  end

  // line_next is the level for the current state; the uart_tx flop makes the line
  // trail the state register by one edge, so every bit still lasts CLOCKS_PER_BIT cycles.
  always_comb begin
    state_next = state;
    baud_next  = '0;
    bit_next   = bit_idx;
    pop        = 1'b0;
    line_next  = 1'b1;
    if (state != S_IDLE) baud_next = bit_done ? '0 : baud_cnt + CNT_W'(1);
    case (state)
      S_IDLE: begin
        bit_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        line_next = 1'b0;
        if (bit_done) state_next = S_DATA;
      end
      S_DATA: begin
        line_next = tx_byte[bit_idx];
        if (bit_done) begin
          bit_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line_next = ^tx_byte;
        if (bit_done) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        line_next = 1'b1;
        // A queued byte chains straight into its start bit with no idle bit between frames.
        if (bit_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// tb_uart_tx_driver: randomized and directed stimulus for uart_tx_driver, checked against a
// frame-timeline model (each pushed byte owns a line window starting at max(push+2, previous end)).
module tb_uart_tx_driver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FL = F * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       uart_tx;
  logic       busy;

  uart_tx_driver #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock_50_000_000(clk),
    .reset(reset),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .uart_tx(uart_tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int         cyc = 0;
  int         start_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  int         last_start = -1000000;
  int         push_count = 0;
  int         last_push_cyc = 0;
  int         s_new;
  logic       acc;

  function automatic logic exp_tx(input int c);
    int s;
    int b;
    for (int i = 0; i < start_q.size(); i++) begin
      s = start_q[i];
      if (c >= s && c < s + FL) begin
        b = (c - s) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return byte_q[i][3'(b - 1)];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^byte_q[i];
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int c);
    for (int i = 0; i < start_q.size(); i++)
      if (c < start_q[i] - 1 + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(input int c);
    int n;
    n = 0;
    for (int i = 0; i < start_q.size(); i++)
      if (start_q[i] - 1 > c) n++;
    return (n < DEPTH);
  endfunction

  function automatic logic [2:0] exp_vec(input int c);
    return {exp_tx(c), exp_busy(c), exp_ready(c)};
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      start_q.delete();
      byte_q.delete();
      exp_q.delete();
      last_start = -1000000;
    end else begin
      acc = data_out_valid && exp_ready(cyc);
      cyc = cyc + 1;
      if (acc) begin
        s_new = (last_start + FL > cyc + 2) ? last_start + FL : cyc + 2;
        start_q.push_back(s_new);
        byte_q.push_back(data_out);
        exp_q.push_back(data_out);
        last_start    = s_new;
        push_count    = push_count + 1;
        last_push_cyc = cyc;
      end
      while (start_q.size() > 0 && start_q[0] + FL + 2 < cyc) begin
        void'(start_q.pop_front());
        void'(byte_q.pop_front());
      end
    end
  end

  // ---------------- scoreboard: per-cycle line state and frame decoding ----------------
  logic       rx_act = 1'b0;
  int         rx_k = 0;
  int         rx_b = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_b;
  logic       ready_low_seen = 1'b0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      rx_act = 1'b0;
    end else begin
      total++;
      if ({uart_tx, busy, data_out_ready} !== exp_vec(cyc)) begin
        bad++;
        if (bad < 30)
          $display("FAIL line_state cyc=%0d got(tx,busy,ready)=%b expected=%b",
                   cyc, {uart_tx, busy, data_out_ready}, exp_vec(cyc));
      end
      if (data_out_ready === 1'b0) ready_low_seen = 1'b1;
      if (!rx_act) begin
        if (uart_tx === 1'b0) begin
          rx_act = 1'b1;
          rx_k   = 0;
        end
      end else begin
        rx_k++;
      end
      if (rx_act && (rx_k % CPB) == CPB / 2) begin
        rx_b = rx_k / CPB;
        if (rx_b >= 1 && rx_b <= 8) rx_byte[3'(rx_b - 1)] = uart_tx;
`ifdef UART_TX_PARITY_EN
        if (rx_b == 9) begin
          total++;
          if (uart_tx !== ^rx_byte) begin
            bad++;
            $display("FAIL parity_bit byte=%h got=%b expected=%b", rx_byte, uart_tx, ^rx_byte);
          end
        end
`endif
        if (rx_b == F - 1) begin
          rx_act = 1'b0;
          rx_q.push_back(rx_byte);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_extra got=%h expected=none", rx_byte);
          end else begin
            exp_b = exp_q.pop_front();
            if (rx_byte !== exp_b || uart_tx !== 1'b1) begin
              bad++;
              $display("FAIL frame_byte got=%h stop=%b expected=%h stop=1", rx_byte, uart_tx, exp_b);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    int pc;
    int n;
    pc = push_count;
    n  = 0;
    data_out       = b;
    data_out_valid = 1'b1;
    while (push_count == pc && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (push_count == pc) begin
      total++;
      bad++;
      $display("FAIL send_timeout byte=%h got=not_accepted expected=accepted", b);
    end
  endtask

  task automatic wait_idle(output int idle_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout got busy=%b expected=0", busy);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset          = 1'b1;
    data_out       = 8'h00;
    data_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    total += 3;
    if (uart_tx !== 1'b1)        begin bad++; $display("FAIL reset_tx got=%b expected=1", uart_tx); end
    if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%b expected=0", busy); end
    if (data_out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b expected=0", data_out_ready); end
    #2 reset = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      total++;
      if ({uart_tx, busy, data_out_ready} !== 3'b101) begin
        bad++;
        if (bad < 30) $display("FAIL idle_line cyc=%0d got=%b expected=101", cyc, {uart_tx, busy, data_out_ready});
      end
    end
  endtask

  task automatic test_single();
    int         p;
    int         ic;
    logic [10:0] pat;
`ifdef UART_TX_PARITY_EN
    pat = 11'b101_0010_0000;
`else
    pat = 11'b111_0010_0000;
`endif
    send(8'h90);
    data_out_valid = 1'b0;
    p = last_push_cyc;
    for (int b = 0; b < F; b++) begin
      wait_cyc(p + 2 + b * CPB + CPB / 2);
      total++;
      if (uart_tx !== pat[b]) begin
        bad++;
        $display("FAIL single_bit%0d got=%b expected=%b", b, uart_tx, pat[b]);
      end
    end
    wait_idle(ic);
    total++;
    if (ic != p + 1 + FL) begin
      bad++;
      $display("FAIL single_busy_fall got=%0d expected=%0d", ic - p, 1 + FL);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int ic;
    rx_q.delete();
    ready_low_seen = 1'b0;
    send(8'h01);
    p = last_push_cyc;
    for (int v = 2; v <= 6; v++) send(8'(v));
    data_out_valid = 1'b0;
    wait_idle(ic);
    total += 3;
    if (ready_low_seen !== 1'b1) begin bad++; $display("FAIL b2b_ready_drop got=0 expected=1"); end
    if (ic != p + 1 + 6 * FL) begin
      bad++;
      $display("FAIL b2b_duration got=%0d expected=%0d", ic - p - 1, 6 * FL);
    end
    if (rx_q.size() != 6) begin
      bad++;
      $display("FAIL b2b_count got=%0d expected=6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (rx_q[i] !== 8'(i + 1)) begin
          bad++;
          $display("FAIL b2b_order idx=%0d got=%h expected=%h", i, rx_q[i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_parity();
    int   p;
    int   ic;
    logic e1;
    logic e2;
`ifdef UART_TX_PARITY_EN
    e1 = 1'b1;
    e2 = 1'b0;
`else
    e1 = 1'b1;
    e2 = 1'b1;
`endif
    send(8'h07);
    p = last_push_cyc;
    send(8'h03);
    data_out_valid = 1'b0;
    wait_cyc(p + 2 + 9 * CPB + CPB / 2);
    total++;
    if (uart_tx !== e1) begin bad++; $display("FAIL parity_07 got=%b expected=%b", uart_tx, e1); end
    wait_cyc(p + 2 + FL + 9 * CPB + CPB / 2);
    total++;
    if (uart_tx !== e2) begin bad++; $display("FAIL parity_03 got=%b expected=%b", uart_tx, e2); end
    wait_idle(ic);
    total++;
    if (ic != p + 1 + 2 * FL) begin
      bad++;
      $display("FAIL parity_frame_len got=%0d expected=%0d", ic - p - 1, 2 * FL);
    end
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic [7:0] b;
    int         gap;
    int         ic;
    rx_q.delete();
    for (int i = 0; i < 12; i++) begin
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 250)) : 0;
      data_out_valid = 1'b0;
      repeat (gap) begin
        data_out = 8'($urandom);
        @(negedge clk);
      end
      b = 8'($urandom);
      sent.push_back(b);
      send(b);
    end
    data_out_valid = 1'b0;
    wait_idle(ic);
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL random_drain got=%0d expected=0", exp_q.size()); end
    if (rx_q.size() != sent.size()) begin
      bad++;
      $display("FAIL random_count got=%0d expected=%0d", rx_q.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        total++;
        if (rx_q[i] !== sent[i]) begin
          bad++;
          $display("FAIL random_order idx=%0d got=%h expected=%h", i, rx_q[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int p;
    int ic;
    send(8'hA5);
    p = last_push_cyc;
    send(8'h5A);
    data_out_valid = 1'b0;
    wait_cyc(p + 2 + 4 * CPB + CPB / 2);
    total++;
    if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_bit3 got=%b expected=0", uart_tx); end
    #2 reset = 1'b1;
    #1;
    total += 3;
    if (uart_tx !== 1'b1)        begin bad++; $display("FAIL mid_reset_tx got=%b expected=1", uart_tx); end
    if (busy !== 1'b0)           begin bad++; $display("FAIL mid_reset_busy got=%b expected=0", busy); end
    if (data_out_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b expected=0", data_out_ready); end
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0)           begin bad++; $display("FAIL post_reset_busy got=%b expected=0", busy); end
    if (data_out_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b expected=1", data_out_ready); end
    rx_q.delete();
    send(8'h3C);
    data_out_valid = 1'b0;
    wait_idle(ic);
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      bad++;
      $display("FAIL post_reset_frame got_count=%0d expected=1 byte 3c", rx_q.size());
    end
  endtask

  task automatic test_loopback();
    logic [7:0] want[3];
    int         ic;
    want[0] = 8'h90;
    want[1] = 8'h3C;
    want[2] = 8'h7F;
    rx_q.delete();
    for (int i = 0; i < 3; i++) send(want[i]);
    data_out_valid = 1'b0;
    wait_idle(ic);
    total++;
    if (rx_q.size() != 3) begin
      bad++;
      $display("FAIL loopback_count got=%0d expected=3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rx_q[i] !== want[i]) begin
          bad++;
          $display("FAIL loopback_byte idx=%0d got=%h expected=%h", i, rx_q[i], want[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_random();
    test_reset_mid();
    test_loopback();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog got=timeout expected=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
